// File: rtl/lcd_hex_composer.sv
// Turns a pair of 32-bit values into two "0xHHHHHHHH" LCD text lines and commits them
// atomically with a refresh pulse, never faster than the printer's minimum period.
module lcd_hex_composer #(
   parameter int unsigned CLK_FREQ_MZ   = 32'd50,
   parameter int unsigned MIN_PERIOD_MS = 32'd20,
   parameter bit          UPPERCASE     = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        value_valid,
   output logic        value_ready,
   input  logic [31:0] value0,
   input  logic [31:0] value1,
   output logic [7:0]  line0 [16],
   output logic [7:0]  line1 [16],
   output logic        refresh
);

   localparam int unsigned HOLDOFF_CYCLES = CLK_FREQ_MZ * 32'd1000 * MIN_PERIOD_MS;
   localparam int unsigned CNT_RAW        = $clog2(HOLDOFF_CYCLES + 32'd1);
   localparam int unsigned CNT_W          = (CNT_RAW < 32'd1) ? 32'd1 : CNT_RAW;
   localparam logic [CNT_W-1:0] HOLDOFF_C = CNT_W'(HOLDOFF_CYCLES);
   localparam logic [7:0] SPACE_C         = 8'h20;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      HOLDOFF = 2'd2,
      COMMIT  = 2'd3
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [2:0]       idx_r;
   logic [31:0]      val0_r;
   logic [31:0]      val1_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             holdoff_done_s;
   logic             handshake_s;
   logic [3:0]       widx_s;
   logic [7:0]       shadow0_r [16];
   logic [7:0]       shadow1_r [16];

   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      logic [7:0] ext;
      ext = {4'h0, nib};
      if (nib < 4'd10) begin
         nibble_to_ascii = 8'h30 + ext;
      end else if (UPPERCASE) begin
         nibble_to_ascii = 8'h41 + (ext - 8'd10);
      end else begin
         nibble_to_ascii = 8'h61 + (ext - 8'd10);
      end
   endfunction

   // The holdoff test looks at the counter's next value, so the COMMIT edge lands exactly
   // HOLDOFF_CYCLES edges after the previous one; the counter reads 0 while refresh is issued.
   assign cnt_inc_s      = (cnt_r == HOLDOFF_C) ? cnt_r : cnt_r + CNT_W'(1);
   assign holdoff_done_s = (cnt_inc_s == HOLDOFF_C);
   assign handshake_s    = (state_r == IDLE) && value_valid && value_ready;
   assign widx_s         = 4'd2 + {1'b0, idx_r};

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (handshake_s) state_s = CONVERT;
            else             state_s = IDLE;
         end
         CONVERT: begin
            if (idx_r == 3'd7) state_s = HOLDOFF;
            else               state_s = CONVERT;
         end
         HOLDOFF: begin
            if (holdoff_done_s) state_s = COMMIT;
            else                state_s = HOLDOFF;
         end
         COMMIT:  state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Datapath: capture, nibble conversion into shadows, holdoff counting and commit
   always_ff @(posedge clk) begin
      if (reset) begin
         value_ready <= 1'b0;
         refresh     <= 1'b0;
         idx_r       <= 3'd0;
         val0_r      <= 32'h0;
         val1_r      <= 32'h0;
         cnt_r       <= {CNT_W{1'b0}};
         for (int i = 0; i < 16; i++) begin
            shadow0_r[4'(i)] <= SPACE_C;
            shadow1_r[4'(i)] <= SPACE_C;
            line0[4'(i)]     <= SPACE_C;
            line1[4'(i)]     <= SPACE_C;
         end
      end else begin
         refresh <= 1'b0;
         if ((state_r == HOLDOFF) && holdoff_done_s) begin
            cnt_r <= {CNT_W{1'b0}};
         end else begin
            cnt_r <= cnt_inc_s;
         end
         case (state_r)
            IDLE: begin
               if (handshake_s) begin
                  val0_r      <= value0;
                  val1_r      <= value1;
                  idx_r       <= 3'd0;
                  value_ready <= 1'b0;
               end else begin
                  value_ready <= 1'b1;
               end
            end
            CONVERT: begin
               // Values shift left so the nibble being converted is always at the top.
               shadow0_r[widx_s] <= nibble_to_ascii(val0_r[31:28]);
               shadow1_r[widx_s] <= nibble_to_ascii(val1_r[31:28]);
               shadow0_r[4'd0]   <= 8'h30;
               shadow0_r[4'd1]   <= 8'h78;
               shadow1_r[4'd0]   <= 8'h30;
               shadow1_r[4'd1]   <= 8'h78;
               for (int k = 10; k < 16; k++) begin
                  shadow0_r[4'(k)] <= SPACE_C;
                  shadow1_r[4'(k)] <= SPACE_C;
               end
               val0_r <= {val0_r[27:0], 4'h0};
               val1_r <= {val1_r[27:0], 4'h0};
               idx_r  <= idx_r + 3'd1;
            end
            HOLDOFF: begin
               idx_r <= idx_r;
            end
            COMMIT: begin
               for (int i = 0; i < 16; i++) begin
                  line0[4'(i)] <= shadow0_r[4'(i)];
                  line1[4'(i)] <= shadow1_r[4'(i)];
               end
               refresh <= 1'b1;
            end
            default: begin
               idx_r <= 3'd0;
            end
         endcase
      end
   end

endmodule
